transport_controller: RTL and testbench
=======================================

// Module: transport_controller
// PURPOSE
//  Tempo and transport sequencer for the step sequencer. Turns Start/Stop/Pause
//  button pulses and a live BPM value into single-cycle StepPulse strobes.
//  Tracks the 16-step position and the loop count, and ends playback after
//  Loops full passes (Loops=0 means play until stopped). Sits between the
//  debounced front-panel inputs and the pattern/voice datapath.
// PARAMETERS
//  ACC_W     40    phase-accumulator width in bits
//  STEP_INC  1466  per-BPM increment = round(2^ACC_W*4/(60*CLK_HZ)); 1466 suits 50 MHz
//  STEPS     16    steps per loop; must be a power of 2; StepIndex width = log2(STEPS)
// PORTS
//  Clock      in   1   system clock; sole clock domain
//  Reset      in   1   synchronous, active-high
//  Start      in   1   1-cycle pulse: (re)start from step 0, loop 0
//  Stop       in   1   1-cycle pulse: halt and clear position
//  Pause      in   1   1-cycle pulse: toggle PLAY<->PAUSED
//  Bpm        in   8   tempo in quarter notes/min, read live; 0 = frozen
//  Loops      in   8   loop count, latched on Start; 0 = infinite
//  StepPulse  out  1   1-cycle strobe at the start of each step
//  StepIndex  out  4   current step, 0..STEPS-1
//  LoopIndex  out  8   completed loops since Start; wraps 255->0 when Loops=0
//  Playing    out  1   high in PLAY
//  Paused     out  1   high in PAUSED
//  Done       out  1   high in DONE
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset: state=IDLE; acc, StepIndex, LoopIndex and Loops_latched cleared.
//    All outputs are 0.
//  - Input priority within one cycle: Reset > Stop > Start > Pause > tempo tick.
//  - States: IDLE, PLAY, PAUSED, DONE.
//  - Start (any state): Loops_latched<=Loops; acc<=0; StepIndex<=0; LoopIndex<=0;
//    state<=PLAY; StepPulse=1 in the next cycle, so step 0 sounds with 1-cycle latency.
//  - Stop (any state): state<=IDLE; acc, StepIndex and LoopIndex cleared.
//  - Pause: PLAY->PAUSED and PAUSED->PLAY. Ignored in IDLE and DONE.
//    acc holds while PAUSED. Resuming emits no pulse.
//  - Tempo (PLAY only): {tick,acc} <= acc + Bpm*STEP_INC, computed at ACC_W+1 bits.
//    Product width is ACC_W; Bpm*STEP_INC < 2^ACC_W is required.
//    Step period = 2^ACC_W/(Bpm*STEP_INC) clocks.
//  - On tick with StepIndex<STEPS-1: StepIndex++, StepPulse=1 in the next cycle.
//  - On tick with StepIndex==STEPS-1 (loop end):
//    * if Loops_latched!=0 and LoopIndex+1==Loops_latched: LoopIndex++,
//      state<=DONE, StepIndex<=0, no pulse;
//    * otherwise: LoopIndex++ (mod 256), StepIndex<=0, StepPulse=1.
//  - Total pulses between Start and DONE is exactly Loops_latched*STEPS.
//  - DONE holds until Start or Stop. LoopIndex keeps its final value.
//  - Bpm changes take effect on the next clock. Bpm=0 stalls PLAY with no pulses.
//  - Start in the same cycle as a tick: Start wins and the tick is discarded.
//  - Reset mid-PLAY: outputs are 0 on the next edge. No residual pulse.
// STRUCTURE
//  - Shared package seq_pkg: state encoding (IDLE/PLAY/PAUSED/DONE),
//    STEPS_PER_LOOP=16, index widths.
//  - Sub-module tempo_nco: phase accumulator. Inputs Clock, Reset, En, Clr, Bpm;
//    output tick (1-cycle).
//  - Top level: FSM, step/loop counters, Loops latch, output registers.
// TESTING  (sim params ACC_W=16, STEP_INC=16: Bpm=64 -> period 64 clocks)
//  1. Reset; Loops=2, Bpm=64, Start -> pulse 1 cycle later at StepIndex=0;
//     32 pulses spaced 64 clocks; Done=1 on the 32nd period; LoopIndex=2.
//  2. Loops=0, Bpm=64, run 20 loops -> no Done; LoopIndex=20.
//     Stop -> IDLE, all indices 0.
//  3. Pause at StepIndex=5 mid-period, hold 500 clocks -> no pulses.
//     Pause again -> next pulse after the remaining period; StepIndex=6.
//  4. Bpm=0 while playing -> no pulses for 1000 clocks.
//     Bpm=128 -> pulses every 32 clocks.
//  5. Start in the same cycle as a tick at StepIndex=9 -> StepIndex=0, LoopIndex=0,
//     exactly one pulse. Start while in DONE restarts the same way.
//  6. Reset asserted mid-PLAY -> all outputs 0 next cycle. Stop and Pause
//     together -> IDLE.

Source files
------------

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared transport states and step/loop index widths
package seq_pkg;

    localparam int STEPS_PER_LOOP = 16;
    localparam int STEP_W         = $clog2(STEPS_PER_LOOP);
    localparam int LOOP_W         = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PLAY   = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } xport_state_e;

endpackage

// File: rtl/tempo_nco.sv
// rtl/tempo_nco.sv - phase accumulator producing one tick per step period
module tempo_nco #(
    parameter int ACC_W    = 40,
    parameter int STEP_INC = 1466
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       En,
    input  logic       Clr,
    input  logic [7:0] Bpm,
    output logic       tick
);

    localparam logic [ACC_W-1:0] INC_K = ACC_W'(STEP_INC);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] inc;
    logic [ACC_W:0]   sum;

    assign inc = {{(ACC_W-8){1'b0}}, Bpm} * INC_K;
    assign sum = {1'b0, acc_q} + {1'b0, inc};

    // The carry out of the accumulator is the step tick; it is only
    // meaningful on cycles where the sum is actually committed.
    assign tick = En & ~Clr & sum[ACC_W];

    always_comb begin
        acc_d = acc_q;
        if (Clr) begin
            acc_d = '0;
        end else if (En) begin
            acc_d = sum[ACC_W-1:0];
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/transport_controller.sv
// rtl/transport_controller.sv - transport FSM, step/loop counters and step strobes
module transport_controller
    import seq_pkg::*;
#(
    parameter int ACC_W    = 40,
    parameter int STEP_INC = 1466,
    parameter int STEPS    = STEPS_PER_LOOP
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     Start,
    input  logic                     Stop,
    input  logic                     Pause,
    input  logic [7:0]               Bpm,
    input  logic [LOOP_W-1:0]        Loops,
    output logic                     StepPulse,
    output logic [$clog2(STEPS)-1:0] StepIndex,
    output logic [LOOP_W-1:0]        LoopIndex,
    output logic                     Playing,
    output logic                     Paused,
    output logic                     Done
);

    localparam int                 IDX_W     = $clog2(STEPS);
    localparam logic [IDX_W-1:0]   LAST_STEP = IDX_W'(STEPS - 1);

    xport_state_e      state_q, state_d;
    logic [IDX_W-1:0]  step_q, step_d;
    logic [LOOP_W-1:0] loop_q, loop_d;
    logic [LOOP_W-1:0] loops_lat_q, loops_lat_d;
    logic              pulse_q, pulse_d;
    logic              playing_q, paused_q, done_q;

    logic nco_en;
    logic nco_clr;
    logic tick;

    // Pause outranks the tempo tick, so the accumulator is frozen on the
    // cycle a pause lands and no step is lost across pause/resume.
    assign nco_clr = Start | Stop;
    assign nco_en  = (state_q == ST_PLAY) & ~Pause;

    tempo_nco #(
        .ACC_W    (ACC_W),
        .STEP_INC (STEP_INC)
    ) u_nco (
        .Clock (Clock),
        .Reset (Reset),
        .En    (nco_en),
        .Clr   (nco_clr),
        .Bpm   (Bpm),
        .tick  (tick)
    );

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        loop_d      = loop_q;
        loops_lat_d = loops_lat_q;
        pulse_d     = 1'b0;

        if (Stop) begin
            state_d = ST_IDLE;
            step_d  = '0;
            loop_d  = '0;
        end else if (Start) begin
            state_d     = ST_PLAY;
            step_d      = '0;
            loop_d      = '0;
            loops_lat_d = Loops;
            pulse_d     = 1'b1;
        end else begin
            unique case (state_q)
                ST_PLAY: begin
                    if (Pause) begin
                        state_d = ST_PAUSED;
                    end else if (tick) begin
                        if (step_q != LAST_STEP) begin
                            step_d  = step_q + 1'b1;
                            pulse_d = 1'b1;
                        end else begin
                            step_d = '0;
                            loop_d = loop_q + 8'd1;
                            if ((loops_lat_q != '0) && (loop_q + 8'd1 == loops_lat_q)) begin
                                state_d = ST_DONE;
                            end else begin
                                pulse_d = 1'b1;
                            end
                        end
                    end
                end
                ST_PAUSED: begin
                    if (Pause) begin
                        state_d = ST_PLAY;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            step_q      <= '0;
            loop_q      <= '0;
            loops_lat_q <= '0;
            pulse_q     <= 1'b0;
            playing_q   <= 1'b0;
            paused_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            loop_q      <= loop_d;
            loops_lat_q <= loops_lat_d;
            pulse_q     <= pulse_d;
            playing_q   <= (state_d == ST_PLAY);
            paused_q    <= (state_d == ST_PAUSED);
            done_q      <= (state_d == ST_DONE);
        end
    end

    assign StepPulse = pulse_q;
    assign StepIndex = step_q;
    assign LoopIndex = loop_q;
    assign Playing   = playing_q;
    assign Paused    = paused_q;
    assign Done      = done_q;

endmodule

// File: tb/tb_transport_controller.sv
// tb/tb_transport_controller.sv - randomized and directed bench with behavioural transport model
module tb_transport_controller;

    localparam int ACC_W    = 16;
    localparam int STEP_INC = 16;
    localparam int STEPS    = 16;
    localparam int FULL     = 65536;

    localparam int M_IDLE   = 0;
    localparam int M_PLAY   = 1;
    localparam int M_PAUSED = 2;
    localparam int M_DONE   = 3;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic       Stop  = 1'b0;
    logic       Pause = 1'b0;
    logic [7:0] Bpm   = 8'd0;
    logic [7:0] Loops = 8'd0;
    logic       StepPulse;
    logic [3:0] StepIndex;
    logic [7:0] LoopIndex;
    logic       Playing;
    logic       Paused;
    logic       Done;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int m_mode  = M_IDLE;
    int m_phase = 0;
    int m_step  = 0;
    int m_loop  = 0;
    int m_limit = 0;
    bit m_pulse = 1'b0;

    transport_controller #(
        .ACC_W    (ACC_W),
        .STEP_INC (STEP_INC),
        .STEPS    (STEPS)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Start     (Start),
        .Stop      (Stop),
        .Pause     (Pause),
        .Bpm       (Bpm),
        .Loops     (Loops),
        .StepPulse (StepPulse),
        .StepIndex (StepIndex),
        .LoopIndex (LoopIndex),
        .Playing   (Playing),
        .Paused    (Paused),
        .Done      (Done)
    );

    initial forever #5 Clock = ~Clock;

    // Model of one clock edge: what the transport must do given the inputs present at that edge.
    task automatic model_edge(input bit rst, input bit stp, input bit sta, input bit pse,
                              input int bpm, input int loops);
        m_pulse = 1'b0;
        if (rst) begin
            m_mode = M_IDLE; m_phase = 0; m_step = 0; m_loop = 0; m_limit = 0;
        end else if (stp) begin
            m_mode = M_IDLE; m_phase = 0; m_step = 0; m_loop = 0;
        end else if (sta) begin
            m_mode = M_PLAY; m_phase = 0; m_step = 0; m_loop = 0; m_limit = loops;
            m_pulse = 1'b1;
        end else if (pse && m_mode == M_PLAY) begin
            m_mode = M_PAUSED;
        end else if (pse && m_mode == M_PAUSED) begin
            m_mode = M_PLAY;
        end else if (m_mode == M_PLAY) begin
            m_phase = m_phase + bpm * STEP_INC;
            if (m_phase >= FULL) begin
                m_phase = m_phase - FULL;
                if (m_step < STEPS - 1) begin
                    m_step  = m_step + 1;
                    m_pulse = 1'b1;
                end else begin
                    m_step = 0;
                    m_loop = (m_loop + 1) % 256;
                    if (m_limit != 0 && m_loop == m_limit) m_mode = M_DONE;
                    else m_pulse = 1'b1;
                end
            end
        end
    endtask

    // Compare on the falling edge, then advance the model with the inputs the next rising edge will sample.
    initial begin
        forever begin
            @(negedge Clock);
            cyc++;
            tests++;
            if ({StepPulse, StepIndex, LoopIndex, Playing, Paused, Done} !==
                {m_pulse, 4'(m_step), 8'(m_loop), m_mode == M_PLAY, m_mode == M_PAUSED, m_mode == M_DONE}) begin
                fails++;
                $display("FAIL model_cmp cyc=%0d got pulse=%0b step=%0d loop=%0d play=%0b pause=%0b done=%0b want pulse=%0b step=%0d loop=%0d play=%0b pause=%0b done=%0b",
                         cyc, StepPulse, StepIndex, LoopIndex, Playing, Paused, Done,
                         m_pulse, m_step, m_loop, m_mode == M_PLAY, m_mode == M_PAUSED, m_mode == M_DONE);
            end
            model_edge(Reset, Stop, Start, Pause, int'(Bpm), int'(Loops));
        end
    end

    task automatic check(input string name, input int got, input int want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic cyc_in(input bit s, input bit t, input bit p);
        @(posedge Clock);
        #2;
        Start = s;
        Stop  = t;
        Pause = p;
    endtask

    task automatic idle_count(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            cyc_in(1'b0, 1'b0, 1'b0);
            if (StepPulse) cnt++;
        end
    endtask

    task automatic idle(input int n);
        int c;
        idle_count(n, c);
    endtask

    // Wait for a pulse (at a given step, or any step when step<0); k = edges waited.
    task automatic wait_pulse(input string name, input int step, input int budget, output int k);
        k = 0;
        do begin
            cyc_in(1'b0, 1'b0, 1'b0);
            k++;
        end while (!(StepPulse && (step < 0 || int'(StepIndex) == step)) && k < budget);
        if (!(StepPulse && (step < 0 || int'(StepIndex) == step))) begin
            tests++;
            fails++;
            $display("FAIL %s: timeout after %0d cycles", name, k);
        end
    endtask

    initial begin
        int k;
        int cnt;

        repeat (3) cyc_in(1'b0, 1'b0, 1'b0);
        Reset = 1'b0;
        cyc_in(1'b0, 1'b0, 1'b0);
        check("reset_pulse", int'(StepPulse), 0);
        check("reset_step", int'(StepIndex), 0);
        check("reset_loop", int'(LoopIndex), 0);
        check("reset_playing", int'(Playing), 0);
        check("reset_paused", int'(Paused), 0);
        check("reset_done", int'(Done), 0);

        // 1: two loops at period 64 -> 32 pulses then DONE
        Loops = 8'd2; Bpm = 8'd64;
        cyc_in(1'b1, 1'b0, 1'b0);
        cyc_in(1'b0, 1'b0, 1'b0);
        check("t1_first_pulse", int'(StepPulse), 1);
        check("t1_first_step", int'(StepIndex), 0);
        idle_count(2048, cnt);
        check("t1_more_pulses", cnt, 31);
        check("t1_done", int'(Done), 1);
        check("t1_loop", int'(LoopIndex), 2);
        check("t1_playing", int'(Playing), 0);

        // 2: infinite loops, then Stop
        Loops = 8'd0;
        cyc_in(1'b1, 1'b0, 1'b0);
        idle(20485);
        check("t2_loop20", int'(LoopIndex), 20);
        check("t2_not_done", int'(Done), 0);
        cyc_in(1'b0, 1'b1, 1'b0);
        cyc_in(1'b0, 1'b0, 1'b0);
        check("t2_stop_playing", int'(Playing), 0);
        check("t2_stop_step", int'(StepIndex), 0);
        check("t2_stop_loop", int'(LoopIndex), 0);

        // 3: pause 21 cycles into step 5, resume -> 43 more increments
        cyc_in(1'b1, 1'b0, 1'b0);
        wait_pulse("t3_step5", 5, 400, k);
        idle(20);
        cyc_in(1'b0, 1'b0, 1'b1);
        idle_count(500, cnt);
        check("t3_paused_flag", int'(Paused), 1);
        check("t3_no_pulse_paused", cnt, 0);
        cyc_in(1'b0, 1'b0, 1'b1);
        wait_pulse("t3_resume", -1, 200, k);
        check("t3_resume_delay", k, 44);
        check("t3_step6", int'(StepIndex), 6);

        // 4: frozen tempo, then double speed
        Bpm = 8'd0;
        idle_count(1000, cnt);
        check("t4_frozen", cnt, 0);
        Bpm = 8'd128;
        wait_pulse("t4_first", -1, 200, k);
        wait_pulse("t4_gap", -1, 200, k);
        check("t4_period32", k, 32);

        // 5: Start lands on the tick that would leave step 9
        Bpm = 8'd64;
        cyc_in(1'b1, 1'b0, 1'b0);
        idle(639);
        check("t5_at_step9", int'(StepIndex), 9);
        cyc_in(1'b1, 1'b0, 1'b0);
        cyc_in(1'b0, 1'b0, 1'b0);
        check("t5_restart_pulse", int'(StepPulse), 1);
        check("t5_restart_step", int'(StepIndex), 0);
        check("t5_restart_loop", int'(LoopIndex), 0);
        idle_count(62, cnt);
        check("t5_single_pulse", cnt, 0);

        // 5b: Start from DONE
        Loops = 8'd1; Bpm = 8'd255;
        cyc_in(1'b1, 1'b0, 1'b0);
        k = 0;
        do begin cyc_in(1'b0, 1'b0, 1'b0); k++; end while (!Done && k < 400);
        check("t5_reached_done", int'(Done), 1);
        cyc_in(1'b1, 1'b0, 1'b0);
        cyc_in(1'b0, 1'b0, 1'b0);
        check("t5_done_restart_pulse", int'(StepPulse), 1);
        check("t5_done_restart_play", int'(Playing), 1);
        check("t5_done_restart_loop", int'(LoopIndex), 0);

        // 6: reset mid-play, then Stop+Pause together
        Loops = 8'd0; Bpm = 8'd64;
        idle(100);
        Reset = 1'b1;
        cyc_in(1'b0, 1'b0, 1'b0);
        Reset = 1'b0;
        check("t6_rst_all", int'({StepPulse, StepIndex, LoopIndex, Playing, Paused, Done}), 0);
        cyc_in(1'b1, 1'b0, 1'b0);
        idle(100);
        cyc_in(1'b0, 1'b1, 1'b1);
        cyc_in(1'b0, 1'b0, 1'b0);
        check("t6_stop_pause_play", int'(Playing), 0);
        check("t6_stop_pause_paused", int'(Paused), 0);
        check("t6_stop_pause_step", int'(StepIndex), 0);

        // Randomized traffic, checked cycle by cycle by the model
        for (int i = 0; i < 15000; i++) begin
            cyc_in($urandom_range(0, 149) == 0, $urandom_range(0, 499) == 0, $urandom_range(0, 149) == 0);
            Reset = ($urandom_range(0, 1999) == 0);
            if ($urandom_range(0, 299) == 0)
                Bpm = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(100, 255));
            if ($urandom_range(0, 99) == 0)
                Loops = 8'($urandom_range(0, 3));
        end
        Reset = 1'b0;
        idle(5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
